// File: rtl/prog_counter_pkg.sv
// Shared encodings for the programmable counter.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Kept free of typedefs so plain Verilog users can include it as well.
package prog_counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

endpackage : prog_counter_pkg

// File: rtl/prog_counter_prescaler.sv
// Enable prescaler: emits tick once every prescale+1 enabled cycles.
// Latency: tick is combinational from the registered phase counter and en.
// Backpressure: none; en = 0 freezes the phase, restart zeroes it.
// Ports: clk, reset_n (async low), en, restart (clear|load from the top),
//        prescale (divisor-1), tick (step strobe for this cycle).
module prog_counter_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  restart,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pc_q;
    logic [PRESCALE_W-1:0] pc_d;

    always_comb begin
        tick = en && (pc_q == prescale);
        pc_d = pc_q;
        if (restart) begin
            pc_d = '0;
        end else if (tick) begin
            pc_d = '0;
        end else if (en) begin
            // If prescale is lowered below pc_q the phase runs on and wraps
            // modulo 2^PRESCALE_W before the next match.
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule : prog_counter_prescaler

// File: rtl/prog_counter.sv
// Programmable up/down counter with limit, wrap/saturate, clear/load and prescaled enable.
// Latency: count_q and tc_pulse update one clk after the qualifying input; at_* are combinational.
// Backpressure: none; every cycle is evaluated with priority clear > load > step.
// Ports: clk, reset_n (async low), en, clear, load, load_val, dir (1=up),
//        mode (1=saturate), limit, prescale -> count_q, tc_pulse, at_limit, at_zero.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  dir,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count_q,
    output logic                  tc_pulse,
    output logic                  at_limit,
    output logic                  at_zero
);

    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             tick;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_dec;

    prog_counter_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .restart  (clear | load),
        .prescale (prescale),
        .tick     (tick)
    );

    assign count_inc = count_q + 1'b1;
    assign count_dec = count_q - 1'b1;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > limit) ? limit : load_val;
        end else if (tick) begin
            if (dir == DIR_UP) begin
                // Compare before stepping so a lowered limit resolves through
                // the terminal branch rather than counting past it.
                if (count_q < limit) begin
                    count_d = count_inc;
                    tc_d    = (mode == MODE_SAT) && (count_inc == limit);
                end else if (mode == MODE_WRAP) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end else begin
                    count_d = limit;
                end
            end else begin
                if (count_q != '0) begin
                    count_d = count_dec;
                    tc_d    = (mode == MODE_SAT) && (count_dec == '0);
                end else if (mode == MODE_WRAP) begin
                    count_d = limit;
                    tc_d    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign tc_pulse = tc_q;
    assign at_limit = (count_q == limit);
    assign at_zero  = (count_q == '0);

endmodule : prog_counter

// File: tb/tb_prog_counter.sv
// Bench for prog_counter: directed table, hand-written corner sequences and
// randomized traffic against a behavioural model.
// Outputs are sampled 1 ns after each rising edge.
module tb_prog_counter;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       clear;
    logic       load;
    logic [7:0] load_val;
    logic       dir;
    logic       mode;
    logic [7:0] limit;
    logic [3:0] prescale;
    logic [7:0] count_q;
    logic       tc_pulse;
    logic       at_limit;
    logic       at_zero;

    int n_vec;
    int n_err;

    prog_counter #(
        .WIDTH      (8),
        .PRESCALE_W (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .mode     (mode),
        .limit    (limit),
        .prescale (prescale),
        .count_q  (count_q),
        .tc_pulse (tc_pulse),
        .at_limit (at_limit),
        .at_zero  (at_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       ld;
        logic [7:0] lv;
        logic       en;
        logic       dir;
        logic       mode;
        logic [7:0] lim;
        int         e_cnt;
        logic       e_tc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic clr, input logic ld, input logic [7:0] lv,
                       input logic e, input logic d, input logic m,
                       input logic [7:0] lim, input int e_cnt, input logic e_tc);
        vec_t v;
        v.clr = clr; v.ld = ld; v.lv = lv; v.en = e; v.dir = d; v.mode = m;
        v.lim = lim; v.e_cnt = e_cnt; v.e_tc = e_tc;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // at_limit / at_zero expectations follow from the expected count and the
    // limit currently driven.
    task automatic check(input string name, input int e_cnt, input logic e_tc);
        logic e_lim;
        logic e_zero;
        e_lim  = (e_cnt == int'(limit));
        e_zero = (e_cnt == 0);
        n_vec++;
        if (int'(count_q) != e_cnt || tc_pulse !== e_tc ||
            at_limit !== e_lim || at_zero !== e_zero) begin
            n_err++;
            $display("FAIL %s: got count=%0d tc=%0b at_limit=%0b at_zero=%0b, want count=%0d tc=%0b at_limit=%0b at_zero=%0b",
                     name, count_q, tc_pulse, at_limit, at_zero, e_cnt, e_tc, e_lim, e_zero);
        end
    endtask

    // Behavioural model: the prescaler is viewed as "ticks on every
    // (prescale+1)-th enabled cycle since the last clear/load".
    int   m_count;
    logic m_tc;
    int   m_en_cnt;

    task automatic model_cycle(input int ps);
        logic t;
        int   lim;
        lim = int'(limit);
        t = en && !clear && !load && (((m_en_cnt + 1) % (ps + 1)) == 0);
        if (clear || load) m_en_cnt = 0;
        else if (en) m_en_cnt++;
        m_tc = 1'b0;
        if (clear) begin
            m_count = 0;
        end else if (load) begin
            m_count = (int'(load_val) < lim) ? int'(load_val) : lim;
        end else if (t) begin
            if (dir) begin
                if (m_count < lim) begin
                    m_count = m_count + 1;
                    if (mode && m_count == lim) m_tc = 1'b1;
                end else if (!mode) begin
                    m_count = 0;
                    m_tc = 1'b1;
                end else begin
                    m_count = lim;
                end
            end else begin
                if (m_count > 0) begin
                    m_count = m_count - 1;
                    if (mode && m_count == 0) m_tc = 1'b1;
                end else if (!mode) begin
                    m_count = lim;
                    m_tc = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int ps;
        n_vec = 0;
        n_err = 0;

        // ---- reset and full-range up count ----
        reset_n = 1'b0; en = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
        dir = 1'b1; mode = 1'b0; limit = 8'd255; prescale = 4'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_hold", 0, 1'b0);
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            step();
            check("up_full_range", i % 256, (i == 256));
        end

        // ---- directed table ----
        add(1,0,0,  1,1,0,5,  0,0);
        add(0,0,0,  1,1,0,5,  1,0);
        add(0,0,0,  1,1,0,5,  2,0);
        add(0,0,0,  1,1,0,5,  3,0);
        add(0,0,0,  1,1,0,5,  4,0);
        add(0,0,0,  1,1,0,5,  5,0);
        add(0,0,0,  1,1,0,5,  0,1);
        add(0,0,0,  1,1,0,5,  1,0);
        add(0,1,3,  1,0,1,5,  3,0);
        add(0,0,0,  1,0,1,5,  2,0);
        add(0,0,0,  1,0,1,5,  1,0);
        add(0,0,0,  1,0,1,5,  0,1);
        add(0,0,0,  1,0,1,5,  0,0);
        add(0,0,0,  1,0,1,5,  0,0);
        add(0,1,7,  1,1,0,20, 7,0);
        add(1,1,9,  1,1,0,20, 0,0);
        add(0,1,200,1,1,1,10, 10,0);
        add(0,0,0,  1,1,1,10, 10,0);
        add(0,0,0,  1,0,1,10, 9,0);
        add(0,0,0,  1,1,1,10, 10,1);
        add(0,0,0,  1,1,0,0,  0,1);
        add(0,0,0,  1,1,0,0,  0,1);
        add(0,0,0,  1,1,1,0,  0,0);
        add(0,1,8,  1,1,0,20, 8,0);
        add(0,0,0,  1,0,0,3,  7,0);
        add(0,0,0,  1,1,0,3,  0,1);
        add(0,0,0,  0,1,0,3,  0,0);
        add(0,0,0,  1,0,0,3,  3,1);
        for (int i = 0; i < tbl.size(); i++) begin
            clear = tbl[i].clr; load = tbl[i].ld; load_val = tbl[i].lv;
            en = tbl[i].en; dir = tbl[i].dir; mode = tbl[i].mode; limit = tbl[i].lim;
            step();
            check($sformatf("table[%0d]", i), tbl[i].e_cnt, tbl[i].e_tc);
        end

        // ---- prescaler: step on every 3rd enabled cycle, en=0 freezes ----
        clear = 1'b1; load = 1'b0; en = 1'b1; dir = 1'b1; mode = 1'b0;
        limit = 8'd255; prescale = 4'd2;
        step();
        check("presc_clear", 0, 1'b0);
        clear = 1'b0;
        begin
            logic [6:0] en_seq;
            int         exp_seq[7];
            en_seq = 7'b1111011;   // applied LSB first: 1,1,0,1,1,1,1
            exp_seq = '{0, 0, 0, 1, 1, 1, 2};
            for (int i = 0; i < 7; i++) begin
                en = en_seq[i];
                step();
                check($sformatf("prescale[%0d]", i), exp_seq[i], 1'b0);
            end
        end

        // ---- async reset with a wrap pulse pending ----
        prescale = 4'd0; en = 1'b1; limit = 8'd4; clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("pre_reset_count", i, 1'b0);
        end
        #2 reset_n = 1'b0;
        #1 check("async_reset", 0, 1'b0);
        step();
        check("reset_held", 0, 1'b0);
        reset_n = 1'b1;
        step();
        check("resume_after_reset", 1, 1'b0);
        step();
        check("resume_after_reset2", 2, 1'b0);

        // ---- randomized traffic against the model ----
        for (int seg = 0; seg < 16; seg++) begin
            ps = $urandom_range(0, 3);
            prescale = 4'(ps);
            clear = 1'b1; load = 1'b0; en = $urandom_range(0, 1);
            limit = 8'($urandom_range(0, 255));
            m_count = 0; m_tc = 1'b0; m_en_cnt = 0;
            model_cycle(ps);
            step();
            check("rand_clear", m_count, m_tc);
            for (int c = 0; c < 200; c++) begin
                clear = ($urandom_range(0, 63) == 0);
                load = ($urandom_range(0, 31) == 0);
                load_val = 8'($urandom);
                en = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 15) == 0) dir = ~dir;
                if ($urandom_range(0, 31) == 0) mode = ~mode;
                if ($urandom_range(0, 49) == 0)
                    limit = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7))
                                                        : 8'($urandom);
                model_cycle(ps);
                step();
                check("random", m_count, m_tc);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_prog_counter
